// File: rtl/prim_pkg.sv
// Shared helpers for the pipelined XOR/NOT primitive array: pair and word
// primitives plus the iteration clamp applied at pipeline entry.
package prim_pkg;

    localparam int unsigned MAX_PAIRS = 64;
    localparam int unsigned MAX_W     = 2 * MAX_PAIRS;

    // One step of the 2-bit sequence 00 -> 01 -> 10 -> 11 -> 00.
    function automatic logic [1:0] prim_pair_f(input logic [1:0] p);
        return {p[1] ^ p[0], ~p[0]};
    endfunction

    // Applies the pair primitive to the lowest n_pairs pairs; upper bits return zero.
    function automatic logic [MAX_W-1:0] prim_word_f(input logic [MAX_W-1:0] w,
                                                     input int unsigned     n_pairs);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < MAX_PAIRS; j++) begin
            if (j < n_pairs) begin
                r[2*j +: 2] = prim_pair_f(w[2*j +: 2]);
            end
        end
        return r;
    endfunction

    function automatic int unsigned clamp_iters_f(input int unsigned iters,
                                                  input int unsigned depth);
        return (iters > depth) ? depth : iters;
    endfunction

endpackage

// File: rtl/prim_stage.sv
// One pipeline register stage: captures valid/data/iters when allowed to load and
// applies the primitive when its index K is below the word's iteration count.
module prim_stage
    import prim_pkg::*;
#(
    parameter int unsigned W    = 16,
    parameter int unsigned IT_W = 3,
    parameter int unsigned K    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            rdy,
    input  logic            up_valid,
    input  logic [W-1:0]    up_data,
    input  logic [IT_W-1:0] up_iters,
    output logic            valid_q,
    output logic [W-1:0]    data_q,
    output logic [IT_W-1:0] iters_q
);

    logic            valid_d;
    logic [W-1:0]    data_d;
    logic [IT_W-1:0] iters_d;
    logic [W-1:0]    prim_data;
    logic            apply;

    always_comb begin
        prim_data = W'(prim_word_f(MAX_W'(up_data), W / 2));
        apply     = (32'(up_iters) > K);
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        iters_d = iters_q;
        if (rdy) begin
            valid_d = up_valid;
            // Data only moves with a real word, so idle stages keep their last value.
            if (up_valid) begin
                data_d  = apply ? prim_data : up_data;
                iters_d = up_iters;
            end
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            iters_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            iters_q <= iters_d;
        end
    end

endmodule

// File: rtl/pipelined_prim_array.sv
// DEPTH-stage valid/ready pipeline applying the pair primitive a per-word number
// of times, with synchronous flush and a wrapping accepted-word counter.
module pipelined_prim_array
    import prim_pkg::*;
#(
    parameter  int unsigned IO_PAIRS = 8,
    parameter  int unsigned DEPTH    = 4,
    parameter  int unsigned CNT_W    = 16,
    localparam int unsigned W        = 2 * IO_PAIRS,
    localparam int unsigned IT_W     = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [IT_W-1:0]  in_iters,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] acc_count
);

    logic            stg_valid [DEPTH];
    logic [W-1:0]    stg_data  [DEPTH];
    logic [IT_W-1:0] stg_iters [DEPTH];
    logic            up_valid  [DEPTH];
    logic [W-1:0]    up_data   [DEPTH];
    logic [IT_W-1:0] up_iters  [DEPTH];
    logic            rdy       [DEPTH];
    logic            all_full;
    logic            unused_iters;

    logic [CNT_W-1:0] acc_d;
    logic [CNT_W-1:0] acc_q;

    // rdy_k = ~valid_k | rdy_{k+1} unrolled: a stage may load unless it and
    // every stage downstream of it are full while the sink stalls.
    always_comb begin
        all_full = 1'b1;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            all_full = all_full & stg_valid[k];
            rdy[k]   = out_ready | ~all_full;
        end
    end

    always_comb begin
        up_valid[0] = in_valid & ~flush;
        up_data[0]  = in_data;
        up_iters[0] = IT_W'(clamp_iters_f(32'(in_iters), DEPTH));
        for (int k = 1; k < int'(DEPTH); k++) begin
            up_valid[k] = stg_valid[k-1];
            up_data[k]  = stg_data[k-1];
            up_iters[k] = stg_iters[k-1];
        end
    end

    for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
        prim_stage #(
            .W    (W),
            .IT_W (IT_W),
            .K    (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .rdy      (rdy[k]),
            .up_valid (up_valid[k]),
            .up_data  (up_data[k]),
            .up_iters (up_iters[k]),
            .valid_q  (stg_valid[k]),
            .data_q   (stg_data[k]),
            .iters_q  (stg_iters[k])
        );
    end

    assign unused_iters = ^stg_iters[DEPTH-1];

    always_comb begin
        in_ready  = rdy[0] & ~flush;
        out_valid = stg_valid[DEPTH-1];
        out_data  = stg_data[DEPTH-1];
        acc_count = acc_q;
    end

    always_comb begin
        acc_d = acc_q;
        if (in_valid && in_ready) begin
            acc_d = acc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: tb/tb_pipelined_prim_array.sv
// Directed bench for pipelined_prim_array: reset, iteration control, streaming,
// backpressure, flush, and counter wrap on a small DEPTH=1 / CNT_W=4 instance.
module tb_pipelined_prim_array;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_iters;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] acc_count;

    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [15:0] s_in_data;
    logic [0:0]  s_in_iters;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_out_data;
    logic [3:0]  s_acc_count;

    int          errors;
    int          checks;
    logic [15:0] exp_acc;

    pipelined_prim_array #(.IO_PAIRS(8), .DEPTH(4), .CNT_W(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_iters  (in_iters),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .acc_count (acc_count)
    );

    pipelined_prim_array #(.IO_PAIRS(8), .DEPTH(1), .CNT_W(4)) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .in_iters  (s_in_iters),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .acc_count (s_acc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_iters = '0; out_ready = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1 || acc_count !== 16'h0000) begin
            errors++;
            $display("FAIL por_state: valid=%b data=%h rdy=%b acc=%h, want 0 0000 1 0000",
                     out_valid, out_data, in_ready, acc_count);
        end
        step();
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_data = 16'h1234; in_iters = 3'd1;
        step(); step(); step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: got %b want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1 || acc_count !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h rdy=%b acc=%h, want 0 0000 1 0000",
                     out_valid, out_data, in_ready, acc_count);
        end
        #1;
        rst_n = 1'b1;
        exp_acc = 16'd0;
        step();
        in_valid = 1'b1; in_data = 16'h0000; in_iters = 3'd1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        exp_acc++;
        step(); step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_latency_early: valid=%b want 0 after 3 edges", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h5555) begin
            errors++;
            $display("FAIL reset_latency: valid=%b data=%h want 1 5555", out_valid, out_data);
        end
    endtask

    task automatic test_iters();
        logic [2:0]  it_tab  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        logic [15:0] exp_tab [6] = '{16'h0000, 16'h5555, 16'hAAAA, 16'hFFFF, 16'h0000, 16'h0000};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 16'h0000; in_iters = it_tab[i];
            step();
            in_valid = 1'b0;
            exp_acc++;
            step(); step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL iters%0d_early: valid=%b want 0", it_tab[i], out_valid);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_tab[i]) begin
                errors++;
                $display("FAIL iters%0d: valid=%b data=%h want 1 %h", it_tab[i], out_valid, out_data, exp_tab[i]);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        // iters=1 advances every pair: zero pairs become 01, low pairs follow the sequence.
        logic [15:0] exp_s [8] = '{16'h5556, 16'h5557, 16'h5554, 16'h5559,
                                   16'h555A, 16'h555B, 16'h5558, 16'h555D};
        out_ready = 1'b1;
        for (int s = 1; s <= 13; s++) begin
            if (s <= 8) begin
                in_valid = 1'b1; in_data = 16'(s); in_iters = 3'd1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (s >= 4 && s <= 11) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_s[s-4]) begin
                    errors++;
                    $display("FAIL stream_word%0d: valid=%b data=%h want 1 %h", s - 4, out_valid, out_data, exp_s[s-4]);
                end
            end else if (s == 3 || s == 12) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_gap_cycle%0d: valid=%b want 0", s, out_valid);
                end
            end
        end
        exp_acc += 16'd8;
        checks++;
        if (acc_count !== exp_acc) begin
            errors++;
            $display("FAIL stream_acc: got %h want %h", acc_count, exp_acc);
        end
    endtask

    task automatic test_backpressure();
        int w;
        int r;
        logic acc_now;
        w = 0;
        out_ready = 1'b0; in_iters = 3'd0; in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_data = 16'hA001 + 16'(w);
            #1;
            checks++;
            if (in_ready !== (c < 4)) begin
                errors++;
                $display("FAIL bp_in_ready_c%0d: got %b want %b", c, in_ready, (c < 4));
            end
            step();
            if (c < 4) w++;
        end
        exp_acc += 16'd4;
        checks++;
        if (acc_count !== exp_acc) begin
            errors++;
            $display("FAIL bp_acc_full: got %h want %h", acc_count, exp_acc);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA001) begin
            errors++;
            $display("FAIL bp_stall_hold: valid=%b data=%h want 1 a001", out_valid, out_data);
        end
        out_ready = 1'b1;
        #1;
        r = 0;
        for (int c = 0; c < 20 && r < 6; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== 16'hA001 + 16'(r)) begin
                    errors++;
                    $display("FAIL bp_order%0d: got %h want %h", r, out_data, 16'hA001 + 16'(r));
                end
                r++;
            end
            acc_now = in_valid & in_ready;
            step();
            if (acc_now) begin
                w++;
                exp_acc++;
                if (w == 6) in_valid = 1'b0;
                else in_data = 16'hA001 + 16'(w);
            end
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (r != 6) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d words want 6", r);
        end
        checks++;
        if (acc_count !== exp_acc) begin
            errors++;
            $display("FAIL bp_acc_final: got %h want %h", acc_count, exp_acc);
        end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h0000; in_iters = 3'd1;
        step(); step(); step();
        exp_acc += 16'd3;
        flush = 1'b1; in_data = 16'hFFFF;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || acc_count !== exp_acc) begin
            errors++;
            $display("FAIL flush_clear: valid=%b acc=%h want 0 %h", out_valid, acc_count, exp_acc);
        end
        step(); step(); step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_ghost: valid=%b want 0", out_valid);
        end
        in_valid = 1'b1; in_data = 16'h0000; in_iters = 3'd2;
        step();
        in_valid = 1'b0;
        exp_acc++;
        step(); step(); step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hAAAA || acc_count !== exp_acc) begin
            errors++;
            $display("FAIL flush_after: valid=%b data=%h acc=%h want 1 aaaa %h", out_valid, out_data, acc_count, exp_acc);
        end
        step();
    endtask

    task automatic test_wrap_small();
        s_out_ready = 1'b1; s_in_iters = 1'b0; s_in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_in_data = 16'(i);
            step();
        end
        s_in_valid = 1'b0;
        step();
        checks++;
        if (s_acc_count !== 4'd1 || s_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_acc: acc=%h valid=%b want 1 0", s_acc_count, s_out_valid);
        end
        // Every pair advances: pair0 10->11, idle pairs 00->01.
        s_in_valid = 1'b1; s_in_data = 16'h0002; s_in_iters = 1'b1;
        step();
        s_in_valid = 1'b0;
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 16'h5557) begin
            errors++;
            $display("FAIL depth1_latency: valid=%b data=%h want 1 5557", s_out_valid, s_out_data);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_acc = '0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_in_iters = '0; s_out_ready = 1'b0;
        test_reset();
        test_iters();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_wrap_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
